// File: rtl/bmp180_i2c_target.sv
// Behavioural BMP180 stand-in on an I2C bus: chip-ID, calibration, ctrl_meas,
// soft-reset and result registers, with a timed conversion from input ports.
module bmp180_i2c_target #(
    parameter logic [6:0]  ADDR        = 7'h77,
    parameter logic [7:0]  CHIP_ID     = 8'h55,
    parameter int unsigned CONV_CYCLES = 225000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scl,
    inout  wire          sda,
    input  logic [175:0] calib,
    input  logic [15:0]  temp_raw,
    input  logic [23:0]  press_raw,
    output logic [7:0]   ctrl,
    output logic         busy,
    output logic         eoc
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  scl_sr, sda_sr;
    logic        scl_rise, scl_fall, start_ev, stop_ev, sda_in, byte_done;
    logic [3:0]  bitcnt;
    logic [7:0]  shreg, rx_byte, ptr, rd_addr, rd_data;
    logic [4:0]  cidx;
    logic        ack_ph, sda_oe, rw, mack;
    logic [7:0]  out_msb, out_lsb, out_xlsb;
    logic [31:0] cnt;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // [1] is the synchronised level, [2] its previous value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sr <= '1;
            sda_sr <= '1;
        end else begin
            scl_sr <= {scl_sr[1:0], scl};
            sda_sr <= {sda_sr[1:0], sda};
        end
    end

    assign scl_rise  = scl_sr[1] & ~scl_sr[2];
    assign scl_fall  = ~scl_sr[1] & scl_sr[2];
    assign start_ev  = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
    assign stop_ev   = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];
    assign sda_in    = sda_sr[1];
    assign rx_byte   = {shreg[6:0], sda_in};
    assign byte_done = scl_rise && (bitcnt == 4'd7);

    // In RACK the byte to preload is the one after the current pointer
    always_comb begin
        rd_addr = (state == S_RACK) ? ptr + 8'd1 : ptr;
        cidx    = 5'(8'hBF - rd_addr);
        rd_data = '0;
        if (rd_addr == 8'hD0)
            rd_data = CHIP_ID;
        else if (rd_addr >= 8'hAA && rd_addr <= 8'hBF)
            rd_data = calib[{cidx, 3'b000} +: 8];
        else if (rd_addr == 8'hF4)
            rd_data = ctrl;
        else if (rd_addr == 8'hF6)
            rd_data = out_msb;
        else if (rd_addr == 8'hF7)
            rd_data = out_lsb;
        else if (rd_addr == 8'hF8)
            rd_data = out_xlsb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start_ev)
            state_n = S_ADDR;
        else if (stop_ev)
            state_n = S_IDLE;
        else begin
            case (state)
                S_ADDR:         if (byte_done) state_n = (rx_byte[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:     if (scl_fall && ack_ph) state_n = rw ? S_RDATA : S_PTR;
                S_PTR, S_WDATA: if (byte_done) state_n = S_WACK;
                S_WACK:         if (scl_fall && ack_ph) state_n = S_WDATA;
                S_RDATA:        if (scl_fall && bitcnt == 4'd8) state_n = S_RACK;
                S_RACK:         if (scl_fall && ack_ph) state_n = mack ? S_RDATA : S_IGNORE;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt   <= '0;
            shreg    <= '0;
            ack_ph   <= 1'b0;
            sda_oe   <= 1'b0;
            rw       <= 1'b0;
            mack     <= 1'b0;
            ptr      <= '0;
            ctrl     <= '0;
            out_msb  <= '0;
            out_lsb  <= '0;
            out_xlsb <= '0;
            busy     <= 1'b0;
            eoc      <= 1'b0;
            cnt      <= '0;
        end else begin
            eoc <= 1'b0;
            if (busy) begin
                if (cnt <= 32'd1) begin
                    busy    <= 1'b0;
                    eoc     <= 1'b1;
                    cnt     <= '0;
                    ctrl[5] <= 1'b0;
                    case (ctrl[4:0])
                        5'h0E: begin
                            out_msb  <= temp_raw[15:8];
                            out_lsb  <= temp_raw[7:0];
                            out_xlsb <= 8'h00;
                        end
                        5'h14: begin
                            out_msb  <= press_raw[23:16];
                            out_lsb  <= press_raw[15:8];
                            out_xlsb <= press_raw[7:0];
                        end
                        default: ;
                    endcase
                end else begin
                    cnt <= cnt - 32'd1;
                end
            end

            if (start_ev || stop_ev) begin
                bitcnt <= '0;
                ack_ph <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (byte_done) begin
                            bitcnt <= '0;
                            ack_ph <= 1'b0;
                            if (state == S_ADDR)
                                rw <= sda_in;
                            else if (state == S_PTR)
                                ptr <= rx_byte;
                            else begin
                                // A register write here overrides a conversion ending this cycle
                                if (ptr == 8'hF4) begin
                                    ctrl <= rx_byte;
                                    if (rx_byte[5]) begin
                                        busy <= 1'b1;
                                        cnt  <= (rx_byte[4:0] == 5'h14) ? (32'(CONV_CYCLES) << rx_byte[7:6])
                                                                        : 32'(CONV_CYCLES);
                                    end
                                end else if (ptr == 8'hE0 && rx_byte == 8'hB6) begin
                                    ctrl     <= '0;
                                    out_msb  <= '0;
                                    out_lsb  <= '0;
                                    out_xlsb <= '0;
                                    cnt      <= '0;
                                    busy     <= 1'b0;
                                end
                                ptr <= ptr + 8'd1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_WACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            ack_ph <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            ack_ph <= 1'b0;
                            bitcnt <= '0;
                            sda_oe <= 1'b0;
                            if (state == S_ADDR_ACK && rw) begin
                                shreg  <= rd_data;
                                sda_oe <= ~rd_data[7];
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise)
                            bitcnt <= bitcnt + 4'd1;
                        else if (scl_fall) begin
                            if (bitcnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                bitcnt <= '0;
                                ack_ph <= 1'b0;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    S_RACK: begin
                        if (scl_rise) begin
                            mack   <= ~sda_in;
                            ack_ph <= 1'b1;
                        end else if (scl_fall && ack_ph) begin
                            ack_ph <= 1'b0;
                            if (mack) begin
                                ptr    <= ptr + 8'd1;
                                shreg  <= rd_data;
                                sda_oe <= ~rd_data[7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bmp180_i2c_target.sv
// Directed bench for bmp180_i2c_target: a bit-banged I2C master with a pull-up
// and a monitor that measures busy length and eoc pulses.
module tb_bmp180_i2c_target;
    localparam int unsigned CONV = 128;
    localparam int Q = 50;

    logic         clk = 1'b0;
    logic         reset, scl, m_sda;
    logic [175:0] calib;
    logic [15:0]  temp_raw;
    logic [23:0]  press_raw;
    logic [7:0]   ctrl;
    logic         busy, eoc;
    wire          sda;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    bmp180_i2c_target #(.ADDR(7'h77), .CHIP_ID(8'h55), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .calib(calib),
        .temp_raw(temp_raw), .press_raw(press_raw), .ctrl(ctrl), .busy(busy), .eoc(eoc)
    );

    int n_chk = 0, n_fail = 0;
    logic [7:0] rbuf [0:31];
    logic mclr = 1'b0;
    int busy_len, eoc_seen;

    always @(posedge clk) begin
        if (mclr) begin
            busy_len <= 0;
            eoc_seen <= 0;
        end else begin
            if (busy) busy_len <= busy_len + 1;
            if (eoc)  eoc_seen <= eoc_seen + 1;
        end
    end

    task automatic mon_clear();
        mclr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mclr = 1'b0;
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
    endtask

    task automatic put_byte(input logic [7:0] b, output logic nak);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(nak);
    endtask

    task automatic get_byte(input logic last, output logic [7:0] b);
        logic x;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            get_bit(x);
            b = {b[6:0], x};
        end
        put_bit(last);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] p, input logic [7:0] d,
                          output logic [2:0] nak);
        i2c_start();
        put_byte(a, nak[2]);
        put_byte(p, nak[1]);
        put_byte(d, nak[0]);
        i2c_stop();
    endtask

    task automatic rd_seq(input logic [7:0] p, input int n, output logic nak);
        logic n0, n1, n2;
        logic [7:0] b;
        i2c_start();
        put_byte(8'hEE, n0);
        put_byte(p, n1);
        i2c_start();
        put_byte(8'hEF, n2);
        nak = n0 | n1 | n2;
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, b);
            rbuf[i] = b;
        end
        i2c_stop();
    endtask

    task automatic wait_idle(output logic to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00", ctrl); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (eoc !== 1'b0) begin n_fail++; $display("FAIL reset_eoc: got %b want 0", eoc); end
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_id_read();
        logic nak;
        rd_seq(8'hD0, 1, nak);
        n_chk++; if (nak !== 1'b0) begin n_fail++; $display("FAIL id_acks: got nak=%b want 0", nak); end
        n_chk++; if (rbuf[0] !== 8'h55) begin n_fail++; $display("FAIL id_byte: got %h want 55", rbuf[0]); end
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL id_release: got %b want 1", sda); end
    endtask

    task automatic test_wrong_addr();
        logic [2:0] nak;
        wr_reg(8'hEC, 8'hF4, 8'h2E, nak);
        repeat (4) @(negedge clk);
        n_chk++; if (nak !== 3'b111) begin n_fail++; $display("FAIL wrong_addr_acks: got %b want 111", nak); end
        n_chk++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL wrong_addr_ctrl: got %h want 00", ctrl); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b want 0", busy); end
    endtask

    task automatic test_calib();
        logic nak;
        logic [7:0] exp_b;
        rd_seq(8'hAA, 23, nak);
        n_chk++; if (nak !== 1'b0) begin n_fail++; $display("FAIL calib_acks: got nak=%b want 0", nak); end
        for (int i = 0; i < 22; i++) begin
            exp_b = 8'(i * 13 + 5);
            n_chk++;
            if (rbuf[i] !== exp_b) begin n_fail++; $display("FAIL calib_byte%0d: got %h want %h", i, rbuf[i], exp_b); end
        end
        n_chk++; if (rbuf[22] !== 8'h00) begin n_fail++; $display("FAIL calib_wrap_c0: got %h want 00", rbuf[22]); end
    endtask

    task automatic test_temp();
        logic [2:0] nak;
        logic to, n;
        temp_raw = 16'h6C50;
        mon_clear();
        wr_reg(8'hEE, 8'hF4, 8'h2E, nak);
        n_chk++; if (nak !== 3'b000) begin n_fail++; $display("FAIL temp_acks: got %b want 000", nak); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL temp_busy: got %b want 1", busy); end
        n_chk++; if (ctrl !== 8'h2E) begin n_fail++; $display("FAIL temp_ctrl_run: got %h want 2e", ctrl); end
        wait_idle(to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL temp_timeout: busy still %b want 0", busy); end
        n_chk++; if (busy_len !== 128) begin n_fail++; $display("FAIL temp_busy_len: got %0d want 128", busy_len); end
        n_chk++; if (eoc_seen !== 1) begin n_fail++; $display("FAIL temp_eoc: got %0d want 1", eoc_seen); end
        n_chk++; if (ctrl !== 8'h0E) begin n_fail++; $display("FAIL temp_ctrl_done: got %h want 0e", ctrl); end
        rd_seq(8'hF6, 3, n);
        n_chk++; if (n !== 1'b0) begin n_fail++; $display("FAIL temp_rd_acks: got %b want 0", n); end
        n_chk++; if (rbuf[0] !== 8'h6C) begin n_fail++; $display("FAIL temp_f6: got %h want 6c", rbuf[0]); end
        n_chk++; if (rbuf[1] !== 8'h50) begin n_fail++; $display("FAIL temp_f7: got %h want 50", rbuf[1]); end
        n_chk++; if (rbuf[2] !== 8'h00) begin n_fail++; $display("FAIL temp_f8: got %h want 00", rbuf[2]); end
        rd_seq(8'hF4, 1, n);
        n_chk++; if (rbuf[0] !== 8'h0E) begin n_fail++; $display("FAIL temp_f4: got %h want 0e", rbuf[0]); end
    endtask

    task automatic test_press();
        logic [2:0] nak;
        logic to, n;
        press_raw = 24'h5D23A0;
        mon_clear();
        wr_reg(8'hEE, 8'hF4, 8'hF4, nak);
        n_chk++; if (ctrl !== 8'hF4) begin n_fail++; $display("FAIL press_ctrl_run: got %h want f4", ctrl); end
        wait_idle(to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL press_timeout: busy still %b want 0", busy); end
        n_chk++; if (busy_len !== 1024) begin n_fail++; $display("FAIL press_busy_len: got %0d want 1024", busy_len); end
        n_chk++; if (eoc_seen !== 1) begin n_fail++; $display("FAIL press_eoc: got %0d want 1", eoc_seen); end
        n_chk++; if (ctrl !== 8'hD4) begin n_fail++; $display("FAIL press_ctrl_done: got %h want d4", ctrl); end
        rd_seq(8'hF6, 3, n);
        n_chk++; if (rbuf[0] !== 8'h5D) begin n_fail++; $display("FAIL press_f6: got %h want 5d", rbuf[0]); end
        n_chk++; if (rbuf[1] !== 8'h23) begin n_fail++; $display("FAIL press_f7: got %h want 23", rbuf[1]); end
        n_chk++; if (rbuf[2] !== 8'hA0) begin n_fail++; $display("FAIL press_f8: got %h want a0", rbuf[2]); end
    endtask

    task automatic test_soft_reset();
        logic [2:0] nak;
        logic n;
        mon_clear();
        wr_reg(8'hEE, 8'hF4, 8'hF4, nak);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL soft_busy_before: got %b want 1", busy); end
        wr_reg(8'hEE, 8'hE0, 8'hB6, nak);
        n_chk++; if (nak !== 3'b000) begin n_fail++; $display("FAIL soft_acks: got %b want 000", nak); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL soft_busy: got %b want 0", busy); end
        n_chk++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL soft_ctrl: got %h want 00", ctrl); end
        repeat (1100) @(negedge clk);
        n_chk++; if (eoc_seen !== 0) begin n_fail++; $display("FAIL soft_eoc: got %0d want 0", eoc_seen); end
        rd_seq(8'hF6, 3, n);
        n_chk++; if ({rbuf[0], rbuf[1], rbuf[2]} !== 24'h0) begin
            n_fail++; $display("FAIL soft_out: got %h%h%h want 000000", rbuf[0], rbuf[1], rbuf[2]);
        end
    endtask

    task automatic test_async_reset();
        logic n0, n1, n2, b7, b6, n;
        i2c_start();
        put_byte(8'hEE, n0);
        put_byte(8'hD0, n1);
        i2c_start();
        put_byte(8'hEF, n2);
        get_bit(b7);
        get_bit(b6);
        n_chk++; if ({n0, n1, n2, b7, b6} !== 5'b00001) begin
            n_fail++; $display("FAIL arst_prefix: got %b want 00001", {n0, n1, n2, b7, b6});
        end
        n_chk++; if (sda !== 1'b0) begin n_fail++; $display("FAIL arst_driving: got %b want 0", sda); end
        reset = 1'b1;
        #1;
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL arst_release: got %b want 1", sda); end
        #9;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rd_seq(8'hD0, 1, n);
        n_chk++; if (n !== 1'b0) begin n_fail++; $display("FAIL arst_reack: got nak=%b want 0", n); end
        n_chk++; if (rbuf[0] !== 8'h55) begin n_fail++; $display("FAIL arst_id: got %h want 55", rbuf[0]); end
    endtask

    initial begin
        reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
        temp_raw = '0; press_raw = '0;
        for (int i = 0; i < 22; i++) calib[175 - 8*i -: 8] = 8'(i * 13 + 5);
        @(negedge clk);
        test_reset();
        test_id_read();
        test_wrong_addr();
        test_calib();
        test_temp();
        test_press();
        test_soft_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bmp180_i2c_target.md
# bmp180_i2c_target

Behavioural I2C target that stands in for a BMP180 pressure sensor on the shared `scl`/`sda` bus. It gives the existing I2C master and BMP180 controller a responder on-chip for bench and board bring-up. It decodes start/stop, address, register-pointer writes, data writes and sequential reads. It emulates the chip-ID, calibration, control and measurement registers, with a timed conversion loaded from input ports.

## Interface
- `ADDR`, 7'h77, 7-bit target address
- `CHIP_ID`, 8'h55, value returned at register 0xD0
- `CONV_CYCLES`, 225000, `clk` cycles per conversion (oss = 0)
- `clk`  input  1  system clock; must be >= 8x SCL rate
- `reset`  input  1  asynchronous, active-high reset
- `scl`  input  1  I2C clock from the master; the target never stretches it
- `sda`  inout  1  open-drain data line, driven only 1'b0 or 1'bz
- `calib`  input  176  calibration bytes; `calib[175:168]` maps to 0xAA, `calib[7:0]` to 0xBF
- `temp_raw`  input  16  raw temperature sampled at end of conversion
- `press_raw`  input  24  raw pressure sampled at end of conversion
- `ctrl`  output  8  current ctrl_meas register (0xF4)
- `busy`  output  1  conversion in progress
- `eoc`  output  1  one-cycle pulse when a conversion result is loaded

## Operation
- Input sync: `scl` and `sda` each pass through 2 flip-flops. Edges are detected on the synchronised copies.
- START: synced `sda` falls while `scl` is high. Legal from any state, including a repeated start. Goes to ADDR and clears the bit counter.
- STOP: synced `sda` rises while `scl` is high. Goes to IDLE from any state and releases `sda`.
- Bits are sampled on the `scl` rising edge, MSB first. `sda` is changed only after a `scl` falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK, IGNORE.
- ADDR: after 8 bits, `[7:1]==ADDR` goes to ADDR_ACK and drives 0 for one SCL period. A mismatch goes to IGNORE (`sda` released until START/STOP).
- After ADDR_ACK, R/W=0 goes to PTR. R/W=1 goes to RDATA, loading the byte at the pointer.
- PTR: the first written byte sets the pointer, then ACK. Subsequent bytes (WDATA) write to the pointer, ACK, then the pointer increments.
- RDATA: drives the byte MSB first (0 as 0, 1 as z). RACK samples the master's bit. ACK reloads the next byte (pointer+1). NACK goes to IGNORE.
- Pointer wraps 0xFF to 0x00.
- Read map: 0xD0 returns CHIP_ID; 0xAA..0xBF return `calib`; 0xF4 returns ctrl; 0xF6..0xF8 return the out registers. Every other address reads 0x00.
- Writable registers: 0xF4 and 0xE0 only. Writes elsewhere are ACKed and discarded.
- Conversion start: a write to 0xF4 with bit 5 (SCO) set stores ctrl and sets `busy`. The counter loads CONV_CYCLES for temperature, or CONV_CYCLES << ctrl[7:6] for pressure.
- Conversion end (counter reaches 0):
  - ctrl[4:0]==0x0E: F6/F7/F8 load `temp_raw[15:8]`, `temp_raw[7:0]`, 0x00.
  - ctrl[4:0]==0x14: F6/F7/F8 load `press_raw[23:16]`, `[15:8]`, `[7:0]`.
  - Any other code: the out registers are unchanged.
  - In all cases ctrl[5] clears, `busy` drops and `eoc` pulses.
- A write to 0xF4 while `busy` restarts the conversion with the new value.
- Soft reset: writing 0xB6 to 0xE0 clears ctrl, the out registers and the counter, and drops `busy`. The bus transaction continues. Any other value written to 0xE0 is ignored.

## Timing
- Reset values: `sda` z, `ctrl` 0x00, `busy` 0, `eoc` 0, out registers 0x00, pointer 0x00, FSM IDLE.
- Edge-detect latency: 3 `clk` from pin change to an internal event.
- ACK and data drive start 1 `clk` after the `scl` falling event and hold through the next falling event.
- Register write commits on the `scl` rising edge of the 8th data bit. `ctrl`/`busy` update the following `clk`.
- `busy` rises 1 `clk` after commit. `eoc` fires exactly CONV_CYCLES(<<oss) `clk` after `busy` rises, and `busy` falls in the same cycle.
- Read data is captured at byte load. A conversion finishing mid-byte does not alter the byte in flight.
- `reset` mid-transfer releases `sda` immediately (asynchronously) and returns the FSM to IDLE.

## Test plan
- ID read: write ptr 0xD0, repeated START, read 1 byte with NACK -> ACKs on addr/ptr, byte 0x55, `sda` released after NACK.
- Wrong address 0x76 -> no ACK (`sda` z) for the whole transaction, no register change.
- Calibration burst: ptr 0xAA, read 22 bytes with ACK -> bytes equal `calib` MSB-first order, pointer ends at 0xC0.
- Temperature conversion: write 0x2E to 0xF4 with `temp_raw`=16'h6C50 -> `busy` high for CONV_CYCLES, `eoc` pulse, then reading F6..F8 returns 0x6C, 0x50, 0x00 and F4 reads 0x0E.
- Pressure with oss=3: write 0xF4 to 0xF4 with `press_raw`=24'h5D23_A0 -> `busy` for 8*CONV_CYCLES, then F6..F8 read 0x5D, 0x23, 0xA0.
- Soft reset and async reset: write 0xB6 to 0xE0 during `busy` -> `busy` 0, `ctrl` 0x00, no `eoc`. Assert `reset` during a read byte -> `sda` z immediately and the next START is ACKed normally.
